alufu_pipe: RTL

// Parametrised, pipelined successor of the single-cycle ALU functional unit in the OoO backend.
// - Accepts one issued ALU op per cycle from its reservation station.
// - Computes the result through STAGES register stages.
// - Buffers finished results in a QDEPTH-entry completion queue.
// - Presents the queue head independently to the CDB and to the ROB, and adds a flush path.

---
 rtl/alufu_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/alufu_pipe.sv
// Pipelined ALU functional unit: 1 op/cycle in, STAGES-deep compute, QDEPTH-entry completion queue.
// Head is offered to CDB and ROB independently; it pops once both have taken it. busy is credit-based.
module alufu_pipe #(
  parameter int DATA_W  = 8,
  parameter int ROBID_W = 4,
  parameter int WBS_W   = 8,
  parameter int FLAG_W  = 8,
  parameter int STAGES  = 2,
  parameter int QDEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   input_transmit,
  input  logic [DATA_W-1:0]      operand,
  input  logic [1:0][DATA_W-1:0] depvals,
  input  logic [WBS_W-1:0]       wbs,
  input  logic [FLAG_W-1:0]      flags,
  input  logic [ROBID_W-1:0]     robid,
  output logic                   busy,
  output logic                   cdb_transmit_out,
  output logic [ROBID_W-1:0]     cdb_id,
  output logic [DATA_W-1:0]      cdb_val,
  input  logic                   cdb_transmit,
  output logic                   rob_transmit_out,
  output logic [ROBID_W-1:0]     robid_out,
  output logic [FLAG_W-1:0]      flags_out,
  output logic [WBS_W-1:0]       wbs_out,
  output logic [DATA_W-1:0]      value_out,
  input  logic                   rob_transmit
);

  localparam int QW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + STAGES) + 1;
  localparam logic [DATA_W-1:0] DW = DATA_W'(DATA_W);

  typedef struct packed {
    logic [ROBID_W-1:0] robid;
    logic [FLAG_W-1:0]  flags;
    logic [WBS_W-1:0]   wbs;
    logic [DATA_W-1:0]  value;
  } ent_t;

  logic [DATA_W-1:0] opa, opb, sh, res;
  logic [3:0]        opc;
  logic              accept;
  ent_t              new_ent;

  always_comb begin
    opa = depvals[0];
    opb = flags[2] ? operand : depvals[1];
    opc = flags[2] ? (flags[3] ? 4'h0 : 4'h4) : operand[DATA_W-1 -: 4];
    sh  = opb % DW;
    res = '0;
    case (opc)
      4'h0: res = opa + opb;
      4'h1: res = opa - opb;
      4'h2: res = opa & opb;
      4'h3: res = opa | opb;
      4'h4: res = opa ^ opb;
      4'h5: res = ~(opa | opb);
      4'h6: res = ~(opa & opb);
      4'h7: res = ~(opa ^ opb);
      4'h8: res = opa << sh;
      4'h9: res = opa >> sh;
      4'hA: res = $signed(opa) >>> sh;
      // sh==0 makes the right-shift term vanish, so ROL by 0 is the identity
      4'hB: res = (opa << sh) | (opa >> (DW - sh));
      4'hC: res = {{(DATA_W-1){1'b0}}, $signed(opa) < $signed(opb)};
      4'hD: res = {{(DATA_W-1){1'b0}}, opa < opb};
      default: res = '0;
    endcase
    new_ent = '{robid: robid, flags: flags, wbs: wbs, value: res};
  end

  // Compute pipeline: result is formed on entry and carried through the remaining stages
  logic [STAGES-1:0] pvld_q;
  ent_t              pipe_q [STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pvld_q <= '0;
    end else if (flush) begin
      pvld_q <= '0;
    end else begin
      pvld_q[0] <= accept;
      for (int i = 1; i < STAGES; i++) pvld_q[i] <= pvld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_q[0] <= new_ent;
    for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
  end

  // Completion queue
  ent_t          mem_q [QDEPTH];
  logic [QW-1:0] wr_ptr_q, rd_ptr_q;
  logic [QW:0]   count_q, count_d;
  logic          cdb_done_q, rob_done_q;
  logic          push, pop, head_vld, cdb_fire, rob_fire;
  logic [CW-1:0] inpipe;
  ent_t          head;

  always_comb begin
    head_vld         = (count_q != '0);
    head             = mem_q[rd_ptr_q];
    push             = pvld_q[STAGES-1];
    cdb_transmit_out = head_vld & ~cdb_done_q;
    rob_transmit_out = head_vld & ~rob_done_q;
    cdb_fire         = cdb_transmit & cdb_transmit_out;
    rob_fire         = rob_transmit & rob_transmit_out;
    pop              = head_vld & (cdb_done_q | cdb_fire) & (rob_done_q | rob_fire);
    count_d          = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    inpipe = '0;
    for (int i = 0; i < STAGES; i++) inpipe = inpipe + CW'(pvld_q[i]);
    busy   = (CW'(count_q) + inpipe) >= CW'(QDEPTH);
    accept = input_transmit & ~busy & ~flush;
    cdb_id    = head_vld ? head.robid : '0;
    cdb_val   = head_vld ? head.value : '0;
    robid_out = head_vld ? head.robid : '0;
    flags_out = head_vld ? head.flags : '0;
    wbs_out   = head_vld ? head.wbs   : '0;
    value_out = head_vld ? head.value : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cdb_done_q <= 1'b0;
      rob_done_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cdb_done_q <= 1'b0;
      rob_done_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      cdb_done_q <= pop ? 1'b0 : (cdb_done_q | cdb_fire);
      rob_done_q <= pop ? 1'b0 : (rob_done_q | rob_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pipe_q[STAGES-1];
  end

endmodule
